fp_ksub_pipe: RTL and testbench

Parametrised pipelined single-precision "constant minus operand" unit: computes y = K − x, where K is a compile-time IEEE-754 binary32 constant and x is a non-negative binary32 operand. It generalises the fixed 1.5 − x stage of the inverse-square-root Newton iteration. It adds:
- a selectable constant;
- a full valid/ready handshake with backpressure;
- a configurable-width sideband that travels with each operand;
- NaN/Inf error detection merged with an upstream error flag.

It sits between the x·y² multiplier and the final multiply of each Newton iteration.

---
 rtl/fp32_pkg.sv | 21 ++
 rtl/fp_ksub_pipe_if.sv | 28 ++
 rtl/fp_lzc27.sv | 15 +
 rtl/fp_ksub_pipe.sv | 141 ++++++++++++++
 tb/tb_fp_ksub_pipe.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/fp32_pkg.sv
// fp32_pkg -- binary32 field layout and shared constants.
// Shared by the Newton-iteration stages: the multipliers and the
// constant-minus-operand unit.
package fp32_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] man;
  } fp32_t;

  localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;
  localparam int          FP32_BIAS = 127;
  localparam logic [7:0]  EXP_MAX   = 8'hFF;

  // An all-ones exponent encodes Inf or NaN.
  function automatic logic is_nan_inf(input logic [7:0] e);
    return e == EXP_MAX;
  endfunction

endpackage

// File: rtl/fp_ksub_pipe_if.sv
// fp_ksub_pipe_if -- stream bundle for fp_ksub_pipe.
//   in_valid/in_ready : input beat handshake
//   x_in, sb_in, err_in : operand magnitude {exp,man}, sideband, upstream error
//   out_valid/out_ready : output beat handshake
//   y_out, sb_out, err_out : signed result, sideband, merged error
// master = producer/consumer side (bench or neighbours), slave = the unit.
interface fp_ksub_pipe_if #(parameter int SB_W = 32);
  logic            in_valid;
  logic            in_ready;
  logic [30:0]     x_in;
  logic [SB_W-1:0] sb_in;
  logic            err_in;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     y_out;
  logic [SB_W-1:0] sb_out;
  logic            err_out;

  modport master (
    output in_valid, x_in, sb_in, err_in, out_ready,
    input  in_ready, out_valid, y_out, sb_out, err_out
  );

  modport slave (
    input  in_valid, x_in, sb_in, err_in, out_ready,
    output in_ready, out_valid, y_out, sb_out, err_out
  );
endinterface

// File: rtl/fp_lzc27.sv
// fp_lzc27 -- combinational leading-zero counter for a 27-bit mantissa
// (hidden + 23 fraction + guard/round/sticky). Shared with the adder path.
//   d_i   : value to scan
//   cnt_o : number of leading zeros, 27 when d_i == 0
module fp_lzc27 (
  input  logic [26:0] d_i,
  output logic [4:0]  cnt_o
);
  // Scan upward; the highest set bit is the last one to write cnt_o.
  always_comb begin
    cnt_o = 5'd27;
    for (int i = 0; i < 27; i++)
      if (d_i[i]) cnt_o = 5'(26 - i);
  end
endmodule

// File: rtl/fp_ksub_pipe.sv
// fp_ksub_pipe -- three-stage pipelined y = K_CONST - x for non-negative
// binary32 x, round-to-nearest-even, valid/ready with global stall.
//   clk, rstn : clock, asynchronous active-low reset
//   io        : fp_ksub_pipe_if slave (input beat, output beat, sideband, error)
// Stages: S1 unpack/compare/swap/align, S2 subtract/LZC,
// S3 normalise/round/pack into the output register.
module fp_ksub_pipe
  import fp32_pkg::*;
#(
  parameter logic [31:0] K_CONST = 32'h3FC0_0000,
  parameter int          SB_W    = 32
) (
  input  logic            clk,
  input  logic            rstn,
  fp_ksub_pipe_if.slave   io
);

  localparam fp32_t       KF     = K_CONST;
  localparam logic [7:0]  K_EXP  = KF.exp;
  localparam logic [26:0] K_MANT = {1'b1, KF.man, 3'b000};

  // One record per stage. In S3 sign/exp/mant[22:0] hold the packed result.
  typedef struct packed {
    logic            valid;
    logic            nan;
    logic            sign;
    logic [7:0]      exp;
    logic [26:0]     mant;
    logic [26:0]     mant_b;
    logic [4:0]      lzc;
    logic [SB_W-1:0] sb;
    logic            err;
  } stage_t;

  stage_t st_q [1:3];
  stage_t s1_d, s2_d, s3_d;

  // No bubble squeezing: the whole pipe moves whenever S3 can drain.
  logic en;
  assign en          = ~st_q[3].valid | io.out_ready;
  assign io.in_ready = en;

  // ---------------- S1: unpack, compare, swap, align
  logic [7:0]  x_exp;
  logic [23:0] x_mant;
  logic        x_gt;
  logic [7:0]  ediff;
  logic [4:0]  sa;
  logic [26:0] mag_s;
  logic [52:0] ext;

  always_comb begin
    x_exp  = io.x_in[30:23];
    // Subnormals flush to +0: zero mantissa makes the align stage a no-op.
    x_mant = (x_exp == 8'd0) ? 24'd0 : {1'b1, io.x_in[22:0]};
    x_gt   = (x_exp != 8'd0) && (io.x_in > {K_EXP, KF.man});

    s1_d        = '0;
    s1_d.valid  = io.in_valid;
    s1_d.nan    = is_nan_inf(x_exp);
    s1_d.sign   = x_gt;
    s1_d.sb     = io.sb_in;
    s1_d.err    = io.err_in | s1_d.nan;
    if (x_gt) begin
      s1_d.exp  = x_exp;
      s1_d.mant = {x_mant, 3'b000};
      mag_s     = K_MANT;
      ediff     = x_exp - K_EXP;
    end else begin
      s1_d.exp  = K_EXP;
      s1_d.mant = K_MANT;
      mag_s     = {x_mant, 3'b000};
      ediff     = K_EXP - x_exp;
    end
    // Past 27 positions every bit lands below the sticky slot anyway.
    sa          = (ediff > 8'd27) ? 5'd27 : ediff[4:0];
    ext         = {mag_s, 26'd0} >> sa;
    s1_d.mant_b = {ext[52:27], |ext[26:0]};
  end

  // ---------------- S2: subtract, leading-zero count
  logic [26:0] diff;
  logic [4:0]  lz;

  assign diff = st_q[1].mant - st_q[1].mant_b;

  fp_lzc27 u_lzc (.d_i(diff), .cnt_o(lz));

  always_comb begin
    s2_d        = st_q[1];
    s2_d.mant   = diff;
    s2_d.mant_b = '0;
    s2_d.lzc    = lz;
  end

  // ---------------- S3: normalise, round, pack
  logic [26:0] norm;
  logic [9:0]  e_n, e_r;
  logic        rnd, carry, zero, uflow, ovf;
  logic [22:0] frac_r;

  always_comb begin
    norm  = st_q[2].mant << st_q[2].lzc;
    zero  = ~norm[26];
    e_n   = {2'b00, st_q[2].exp} - {5'd0, st_q[2].lzc};
    // RNE on guard norm[2], round/sticky norm[1:0], lsb norm[3].
    rnd   = norm[2] & (norm[3] | norm[1] | norm[0]);
    {carry, frac_r} = {1'b0, norm[25:3]} + {23'd0, rnd};
    e_r   = e_n + {9'd0, carry};
    uflow = e_n[9] | (e_n == 10'd0);
    ovf   = ~uflow & (e_r >= 10'd255);

    s3_d       = '0;
    s3_d.valid = st_q[2].valid;
    s3_d.sb    = st_q[2].sb;
    s3_d.err   = st_q[2].err | ovf;
    if (st_q[2].nan || ovf) begin
      {s3_d.sign, s3_d.exp, s3_d.mant[22:0]} = FP32_QNAN;
    end else if (!zero && !uflow) begin
      s3_d.sign       = st_q[2].sign;
      s3_d.exp        = e_r[7:0];
      s3_d.mant[22:0] = frac_r;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 1; i <= 3; i++) st_q[i] <= '0;
    end else if (en) begin
      st_q[1] <= s1_d;
      st_q[2] <= s2_d;
      st_q[3] <= s3_d;
    end
  end

  assign io.out_valid = st_q[3].valid;
  assign io.y_out     = {st_q[3].sign, st_q[3].exp, st_q[3].mant[22:0]};
  assign io.sb_out    = st_q[3].sb;
  assign io.err_out   = st_q[3].err;

endmodule

// File: tb/tb_fp_ksub_pipe.sv
// Directed bench for fp_ksub_pipe: K=1.5/SB_W=32 main unit plus a
// K=3.0/SB_W=8 unit fed the same stream.
module tb_fp_ksub_pipe;
  import fp32_pkg::*;

  localparam logic [31:0] ONE = {1'b0, 8'(FP32_BIAS), 23'd0};

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid, err_in, out_ready;
  logic [31:0] x, sb;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  fp_ksub_pipe_if #(.SB_W(32)) io ();
  fp_ksub_pipe_if #(.SB_W(8))  io8 ();

  assign io.in_valid   = in_valid;
  assign io.x_in       = x[30:0];
  assign io.sb_in      = sb;
  assign io.err_in     = err_in;
  assign io.out_ready  = out_ready;
  assign io8.in_valid  = in_valid;
  assign io8.x_in      = x[30:0];
  assign io8.sb_in     = sb[7:0];
  assign io8.err_in    = err_in;
  assign io8.out_ready = out_ready;

  fp_ksub_pipe #(.K_CONST(32'h3FC0_0000), .SB_W(32)) dut  (.clk(clk), .rstn(rstn), .io(io));
  fp_ksub_pipe #(.K_CONST(32'h4040_0000), .SB_W(8))  dut2 (.clk(clk), .rstn(rstn), .io(io8));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One beat; counts negedges after the accepting edge until out_valid.
  task automatic send_one(input string tag, input logic [31:0] xv, input logic [31:0] sbv,
                          input logic ein, input logic [31:0] ey, input logic ee,
                          input bit chk2, input logic [31:0] ey2);
    int n;
    @(negedge clk);
    in_valid = 1'b1; x = xv; sb = sbv; err_in = ein;
    #1 chk({tag, "_in_ready"}, 64'(io.in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (!io.out_valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'd3);
    chk({tag, "_y"},   64'(io.y_out),   64'(ey));
    chk({tag, "_err"}, 64'(io.err_out), 64'(ee));
    chk({tag, "_sb"},  64'(io.sb_out),  64'(sbv));
    if (chk2) chk({tag, "_k3_y"}, 64'(io8.y_out), 64'(ey2));
  endtask

  logic [31:0] bp_x [10] = '{32'h3F000000, 32'h3F800000, 32'h3FC00000, 32'h40000000,
                             32'h3E800000, 32'h40400000, 32'h00000000, 32'h3F400000,
                             32'h40800000, 32'h3DCCCCCD};
  logic [31:0] bp_y [10] = '{32'h3F800000, 32'h3F000000, 32'h00000000, 32'hBF000000,
                             32'h3FA00000, 32'hBFC00000, 32'h3FC00000, 32'h3F400000,
                             32'hC0200000, 32'h3FB33333};

  initial begin
    int tx, rx, rx8, irdy_lo, vcnt;
    bit hold;
    logic [31:0] h_y, h_sb;
    logic        h_err;

    in_valid = 0; x = 0; sb = 0; err_in = 0; out_ready = 1;
    rstn = 1'b1;
    #1 rstn = 1'b0;
    #2;
    chk("rst_out_valid", 64'(io.out_valid), 64'd0);
    chk("rst_y",         64'(io.y_out),     64'd0);
    chk("rst_sb",        64'(io.sb_out),    64'd0);
    chk("rst_err",       64'(io.err_out),   64'd0);
    chk("rst_in_ready",  64'(io.in_ready),  64'd1);
    chk("rst_k3_valid",  64'(io8.out_valid), 64'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    // Basic values and specials, K = 1.5
    send_one("half",   32'h3F000000, 32'hDEADBEEF, 0, 32'h3F800000, 0, 0, 0);
    send_one("equal",  32'h3FC00000, 32'h00000011, 0, 32'h00000000, 0, 0, 0);
    send_one("two",    32'h40000000, 32'h00000022, 0, 32'hBF000000, 0, 0, 0);
    send_one("tie",    32'h33800000, 32'h00000033, 0, 32'h3FC00000, 0, 0, 0);
    send_one("ulp",    32'h34000000, 32'h00000044, 0, 32'h3FBFFFFF, 0, 0, 0);
    send_one("inf",    32'h7F800000, 32'h00000055, 0, 32'h7FC00000, 1, 1, 32'h7FC00000);
    send_one("subn",   32'h00000001, 32'h00000066, 0, 32'h3FC00000, 0, 0, 0);
    send_one("err_in", 32'h3F000000, 32'h00000077, 1, 32'h3F800000, 1, 0, 0);
    send_one("k3",     ONE,          32'h00000088, 0, 32'h3F000000, 0, 1, 32'h40000000);

    // Backpressure: 10 beats, out_ready low for cycles 6..10
    tx = 0; rx = 0; rx8 = 0; irdy_lo = 0; hold = 0;
    h_y = 0; h_sb = 0; h_err = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      out_ready = !(c >= 6 && c < 11);
      in_valid  = (tx < 10);
      x         = (tx < 10) ? bp_x[tx] : 32'd0;
      sb        = 32'(tx);
      err_in    = 1'b0;
      #1;
      if (hold) begin
        chk("bp_hold_y",   64'(io.y_out),   64'(h_y));
        chk("bp_hold_sb",  64'(io.sb_out),  64'(h_sb));
        chk("bp_hold_err", 64'(io.err_out), 64'(h_err));
      end
      hold = 0;
      if (!io.in_ready) irdy_lo++;
      if (io.out_valid && !out_ready) begin
        hold = 1; h_y = io.y_out; h_sb = io.sb_out; h_err = io.err_out;
      end
      if (io.out_valid && out_ready) begin
        chk("bp_y",   64'(io.y_out),   64'((rx < 10) ? bp_y[rx] : 32'hxxxxxxxx));
        chk("bp_sb",  64'(io.sb_out),  64'(rx));
        chk("bp_err", 64'(io.err_out), 64'd0);
        rx++;
      end
      if (io8.out_valid && out_ready) begin
        chk("bp_sb8", 64'(io8.sb_out), 64'(rx8[7:0]));
        rx8++;
      end
      if (in_valid && io.in_ready) tx++;
    end
    in_valid = 0;
    chk("bp_sent",      64'(tx),      64'd10);
    chk("bp_received",  64'(rx),      64'd10);
    chk("bp_received8", 64'(rx8),     64'd10);
    chk("bp_in_ready_low_cycles", 64'(irdy_lo), 64'd5);

    // Reset with three beats in flight
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1; x = 32'h3F000000; sb = 32'(100 + i);
    end
    @(negedge clk);
    in_valid = 0;
    #1 chk("mid_pre_valid", 64'(io.out_valid), 64'd1);
    rstn = 1'b0;
    #1 chk("mid_async_drop", 64'(io.out_valid), 64'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    vcnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (io.out_valid || io8.out_valid) vcnt++;
    end
    chk("mid_no_stale", 64'(vcnt), 64'd0);
    send_one("post_rst", 32'h3F000000, 32'h000000AA, 0, 32'h3F800000, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
